// File: rtl/motion_frame_sequencer_pkg.sv
// rtl/motion_frame_sequencer_pkg.sv - shared defaults, state enum and pixel type for the motion frame sequencer
package motion_pkg;
  localparam int unsigned FRAME_W_DEF = 1280;
  localparam int unsigned FRAME_H_DEF = 720;
  localparam int unsigned CNT_W       = 12;

  typedef logic [31:0]      pixel_t;
  typedef logic [CNT_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } mfs_state_e;
endpackage

// File: rtl/motion_frame_sequencer_if.sv
// rtl/motion_frame_sequencer_if.sv - pixel stream handshake bundle between camera source and sequencer
interface motion_frame_sequencer_if;
  import motion_pkg::*;

  logic   s_tvalid;
  logic   s_tready;
  pixel_t s_tdata;
  logic   s_tlast;
  logic   s_tuser;

  modport master (output s_tvalid, s_tdata, s_tlast, s_tuser, input s_tready);
  modport slave  (input s_tvalid, s_tdata, s_tlast, s_tuser, output s_tready);
endinterface

// File: rtl/motion_frame_sequencer_raster_counter.sv
// rtl/motion_frame_sequencer_raster_counter.sv - x/y raster position with end-of-line and end-of-frame flags
module mfs_raster_counter
  import motion_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_W_DEF,
  parameter int unsigned FRAME_H = FRAME_H_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic at_eol,
  output logic at_eof
);
  coord_t x_q, x_d, y_q, y_d;

  assign at_eol = (x_q == coord_t'(FRAME_W - 1));
  assign at_eof = at_eol && (y_q == coord_t'(FRAME_H - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance) begin
      if (at_eol) begin
        x_d = '0;
        y_d = at_eof ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/motion_frame_sequencer.sv
// rtl/motion_frame_sequencer.sv - frame-locks a pixel stream for the frame manager, padding broken frames
// Optional MFS_ERR_STATS_EN adds the saturating err_total error counter.
module motion_frame_sequencer
  import motion_pkg::*;
#(
  parameter int unsigned FRAME_W       = FRAME_W_DEF,
  parameter int unsigned FRAME_H       = FRAME_H_DEF,
  parameter int unsigned WARMUP_FRAMES = 2,
  parameter int unsigned BG_PERIOD     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  motion_frame_sequencer_if.slave s_axis,
  input  logic                    dn_ready,
  output pixel_t                  fm_pixel,
  output logic                    fm_enable,
  output logic                    fm_last_in_frame,
  output logic                    fm_wr_background,
  output logic                    motion_valid,
  output logic [15:0]             frame_count,
  output logic                    err_early_eol,
  output logic                    err_late_eol,
  output logic                    err_sof
`ifdef MFS_ERR_STATS_EN
  ,
  output logic [7:0]              err_total
`endif
);
  localparam int unsigned BG_W = (BG_PERIOD > 1) ? $clog2(BG_PERIOD) : 1;
  typedef logic [BG_W-1:0] phase_t;

  mfs_state_e  state_q, state_d;
  pixel_t      pixel_q, pixel_d;
  logic        enable_q, enable_d, last_q, last_d, wr_bg_q, wr_bg_d;
  logic        early_q, early_d, late_q, late_d, sof_q, sof_d;
  logic        mv_q, mv_d;
  logic [15:0] fcount_q, fcount_d;
  phase_t      phase_q, phase_d;
  logic        accept, sof_err, fwd, pad, beat, eol_early, eol_late, at_eol, at_eof, bg_due;

  assign s_axis.s_tready = rst && dn_ready && (state_q != ST_FLUSH);
  assign accept    = s_axis.s_tvalid && s_axis.s_tready;
  // In ACTIVE the raster is never at (0,0), so any start-of-frame there is misplaced.
  assign sof_err   = accept && (state_q == ST_ACTIVE) && s_axis.s_tuser;
  assign fwd       = accept && !sof_err && ((state_q == ST_ACTIVE) || s_axis.s_tuser);
  assign pad       = (state_q == ST_FLUSH) && dn_ready;
  assign beat      = fwd || pad;
  assign eol_early = fwd && s_axis.s_tlast && !at_eol;
  assign eol_late  = fwd && !s_axis.s_tlast && at_eol;
  assign bg_due    = (32'(fcount_q) < WARMUP_FRAMES) || (phase_q == '0);

  mfs_raster_counter #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) u_raster (
    .clk     (clk),
    .rst     (rst),
    .advance (beat),
    .at_eol  (at_eol),
    .at_eof  (at_eof)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sof_err)                   state_d = ST_FLUSH;
    else if (beat && at_eof)       state_d = ST_IDLE;
    else if (eol_early || eol_late) state_d = ST_FLUSH;
    else if (fwd)                  state_d = ST_ACTIVE;
  end

  always_comb begin
    pixel_d  = pixel_q;
    last_d   = last_q;
    wr_bg_d  = wr_bg_q;
    enable_d = beat;
    early_d  = eol_early;
    late_d   = eol_late;
    sof_d    = sof_err;
    fcount_d = fcount_q;
    phase_d  = phase_q;
    if (beat) begin
      pixel_d = fwd ? s_axis.s_tdata : '0;
      last_d  = at_eof;
      wr_bg_d = fwd && bg_due && !eol_early && !eol_late;
    end
    // A frame whose final beat lacks tlast is still closed out but not counted as good.
    if (fwd && at_eof && !eol_late) begin
      fcount_d = fcount_q + 16'd1;
      phase_d  = (phase_q == phase_t'(BG_PERIOD - 1)) ? '0 : phase_q + phase_t'(1);
    end
    mv_d = mv_q || (32'(fcount_d) >= WARMUP_FRAMES);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_q  <= '0;
      enable_q <= 1'b0;
      last_q   <= 1'b0;
      wr_bg_q  <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      sof_q    <= 1'b0;
      mv_q     <= 1'b0;
      fcount_q <= '0;
      phase_q  <= '0;
    end else begin
      pixel_q  <= pixel_d;
      enable_q <= enable_d;
      last_q   <= last_d;
      wr_bg_q  <= wr_bg_d;
      early_q  <= early_d;
      late_q   <= late_d;
      sof_q    <= sof_d;
      mv_q     <= mv_d;
      fcount_q <= fcount_d;
      phase_q  <= phase_d;
    end
  end

  assign fm_pixel         = pixel_q;
  assign fm_enable        = enable_q;
  assign fm_last_in_frame = last_q;
  assign fm_wr_background = wr_bg_q;
  assign motion_valid     = mv_q;
  assign frame_count      = fcount_q;
  assign err_early_eol    = early_q;
  assign err_late_eol     = late_q;
  assign err_sof          = sof_q;

`ifdef MFS_ERR_STATS_EN
  logic [7:0] err_total_q, err_total_d;

  always_comb begin
    err_total_d = err_total_q;
    if ((eol_early || eol_late || sof_err) && (err_total_q != 8'hFF))
      err_total_d = err_total_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) err_total_q <= '0;
    else      err_total_q <= err_total_d;
  end

  assign err_total = err_total_q;
`endif
endmodule

// File: tb/tb_motion_frame_sequencer.sv
// tb/tb_motion_frame_sequencer.sv - self-checking bench for motion_frame_sequencer against a frame-level model
module tb_motion_frame_sequencer;
  import motion_pkg::*;

  localparam int W = 4, H = 2, WARM = 2, BGP = 4, FS = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dn_ready = 1'b0;
  always #5 clk = ~clk;

  motion_frame_sequencer_if bus ();

  pixel_t      fm_pixel;
  logic        fm_enable, fm_last_in_frame, fm_wr_background, motion_valid;
  logic [15:0] frame_count;
  logic        err_early_eol, err_late_eol, err_sof;
`ifdef MFS_ERR_STATS_EN
  logic [7:0]  err_total;
`endif

  motion_frame_sequencer #(.FRAME_W(W), .FRAME_H(H), .WARMUP_FRAMES(WARM), .BG_PERIOD(BGP)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis           (bus.slave),
    .dn_ready         (dn_ready),
    .fm_pixel         (fm_pixel),
    .fm_enable        (fm_enable),
    .fm_last_in_frame (fm_last_in_frame),
    .fm_wr_background (fm_wr_background),
    .motion_valid     (motion_valid),
    .frame_count      (frame_count),
    .err_early_eol    (err_early_eol),
    .err_late_eol     (err_late_eol),
    .err_sof          (err_sof)
`ifdef MFS_ERR_STATS_EN
    ,
    .err_total        (err_total)
`endif
  );

  // Frame-level model: linear pixel index within the frame plus in-frame / flushing flags.
  int        m_pos, m_good, m_phase, e_errtot;
  bit        m_active, m_flush, m_mv;
  bit [31:0] e_pixel;
  bit        e_en, e_last, e_bg, e_early, e_late, e_sof;

  always @(posedge clk) begin
    bit acc, islast, early, late;
    if (!rst) begin
      m_pos = 0; m_good = 0; m_phase = 0; e_errtot = 0;
      m_active = 0; m_flush = 0; m_mv = 0;
      e_pixel = 0; e_en = 0; e_last = 0; e_bg = 0; e_early = 0; e_late = 0; e_sof = 0;
    end else begin
      acc = bus.s_tvalid && dn_ready && !m_flush;
      e_en = 0; e_early = 0; e_late = 0; e_sof = 0;
      if (m_flush && dn_ready) begin
        e_en = 1; e_pixel = 0; e_bg = 0; e_last = (m_pos == FS - 1);
        if (e_last) begin m_flush = 0; m_pos = 0; end
        else m_pos++;
      end else if (acc && m_active && bus.s_tuser) begin
        e_sof = 1; m_active = 0; m_flush = 1;
      end else if (acc && (m_active || bus.s_tuser)) begin
        islast = (m_pos == FS - 1);
        early  = bus.s_tlast && (m_pos % W != W - 1);
        late   = !bus.s_tlast && (m_pos % W == W - 1);
        e_en = 1; e_pixel = bus.s_tdata; e_last = islast;
        e_bg = (m_good < WARM || m_phase == 0) && !early && !late;
        e_early = early; e_late = late;
        if (islast) begin
          m_active = 0; m_pos = 0;
          if (!late) begin m_good++; m_phase = (m_phase + 1) % BGP; end
        end else begin
          m_pos++;
          m_active = !(early || late);
          m_flush  = early || late;
        end
      end
      if (m_good >= WARM) m_mv = 1;
      if ((e_early || e_late || e_sof) && e_errtot < 255) e_errtot++;
    end
  end

  int checks = 0, errors = 0;
  int n_en, n_last, n_pad, n_bg, n_early, n_sof;
  int last_idx[$];
  int dn_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (dn_mode)
      0:       dn_ready = 1'b1;
      1:       dn_ready = !dn_ready;
      default: dn_ready = ($urandom_range(0, 4) != 0);
    endcase
  endtask

  task automatic idle(input int n);
    bus.s_tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input pixel_t d, input bit u, input bit l);
    bit got = 0;
    int n = 0;
    bus.s_tvalid = 1'b1; bus.s_tdata = d; bus.s_tuser = u; bus.s_tlast = l;
    while (!got && n < 64) begin
      @(negedge clk);
      got = bus.s_tready;
      step();
      n++;
    end
    if (!got) chk("send_accept_timeout", 64'(got), 1);
    bus.s_tvalid = 1'b0;
  endtask

  task automatic beats(input int first, input int count);
    for (int i = first; i < first + count; i++)
      send($urandom | 32'h1, i == 0, (i % W) == W - 1);
  endtask

  initial begin
    int s_en, s_last, s_bg, s_pad, s_early, s_sof, idx;
    bit u, l;
    bus.s_tvalid = 0; bus.s_tdata = 0; bus.s_tuser = 0; bus.s_tlast = 0;
    dn_mode = 0;
    fork
      forever begin
        @(negedge clk);
        chk("s_tready", bus.s_tready, rst && dn_ready && !m_flush);
        chk("fm_enable", fm_enable, e_en);
        chk("fm_pixel", fm_pixel, e_pixel);
        chk("fm_last_in_frame", fm_last_in_frame, e_last);
        chk("fm_wr_background", fm_wr_background, e_bg);
        chk("err_early_eol", err_early_eol, e_early);
        chk("err_late_eol", err_late_eol, e_late);
        chk("err_sof", err_sof, e_sof);
        chk("frame_count", frame_count, 16'(m_good));
        chk("motion_valid", motion_valid, m_mv);
`ifdef MFS_ERR_STATS_EN
        chk("err_total", err_total, e_errtot);
`endif
        if (fm_enable) begin
          n_en++;
          if (fm_last_in_frame) begin n_last++; last_idx.push_back(n_en); end
          if (fm_pixel == 0) n_pad++;
          if (fm_wr_background) n_bg++;
        end
        n_early += int'(err_early_eol);
        n_sof   += int'(err_sof);
      end
    join_none

    dn_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_tready", bus.s_tready, 0);
    chk("reset_enable", fm_enable, 0);
    chk("reset_frame_count", frame_count, 0);
    chk("reset_motion_valid", motion_valid, 0);
    step();
    rst = 1'b1;
    step();

    // Beats without start-of-frame are discarded while idle.
    s_en = n_en;
    repeat (3) send($urandom | 32'h1, 0, 0);
    idle(2);
    chk("pre_sof_dropped", n_en - s_en, 0);

    // Three clean frames.
    s_en = n_en; s_last = n_last; s_bg = n_bg;
    last_idx.delete();
    beats(0, FS);
    idle(2);
    chk("mv_after_frame1", motion_valid, 0);
    beats(0, FS);
    idle(2);
    chk("mv_after_frame2", motion_valid, 1);
    beats(0, FS);
    idle(3);
    chk("clean_enable_count", n_en - s_en, 24);
    chk("clean_last_count", n_last - s_last, 3);
    chk("clean_last_positions", last_idx.size(), 3);
    for (int i = 0; i < 3 && i < last_idx.size(); i++)
      chk("clean_last_beat", last_idx[i] - s_en, 8 * (i + 1));
    chk("clean_frame_count", frame_count, 3);
    chk("clean_bg_beats", n_bg - s_bg, 16);

    // Frames 4 and 5 with dn_ready toggling every cycle.
    dn_mode = 1;
    s_en = n_en; s_bg = n_bg;
    beats(0, FS);
    idle(4);
    chk("stall_frame4_bg", n_bg - s_bg, 0);
    s_bg = n_bg;
    beats(0, FS);
    idle(4);
    chk("stall_frame5_bg", n_bg - s_bg, 8);
    chk("stall_enable_count", n_en - s_en, 16);
    chk("stall_frame_count", frame_count, 5);
    dn_mode = 0;
    step();

    // Early end-of-line at x=1, y=0.
    s_early = n_early; s_pad = n_pad; s_last = n_last;
    send($urandom | 32'h1, 1, 0);
    send($urandom | 32'h1, 0, 1);
    idle(10);
    chk("early_pulses", n_early - s_early, 1);
    chk("early_pad_beats", n_pad - s_pad, 6);
    chk("early_last_count", n_last - s_last, 1);
    chk("early_frame_count", frame_count, 5);

    // Misplaced start-of-frame at x=2, y=1, then a normal frame.
    s_sof = n_sof; s_pad = n_pad;
    beats(0, 6);
    send($urandom | 32'h1, 1, 0);
    idle(6);
    chk("sof_pulses", n_sof - s_sof, 1);
    chk("sof_pad_beats", n_pad - s_pad, 2);
    beats(0, FS);
    idle(3);
    chk("sof_recover_frame_count", frame_count, 6);

    // Reset on the fifth beat of a frame.
    beats(0, 4);
    bus.s_tvalid = 1'b1; bus.s_tdata = 32'h5a5a_0005; bus.s_tuser = 0; bus.s_tlast = 0;
    rst = 1'b0;
    step();
    bus.s_tvalid = 1'b0;
    @(negedge clk);
    chk("midreset_enable", fm_enable, 0);
    chk("midreset_pixel", fm_pixel, 0);
    chk("midreset_frame_count", frame_count, 0);
    chk("midreset_motion_valid", motion_valid, 0);
    step();
    rst = 1'b1;
    step();
    beats(0, FS);
    idle(3);
    chk("post_reset_frame_count", frame_count, 1);

    // Randomized traffic with occasional protocol faults, checked cycle by cycle.
    dn_mode = 2;
    idx = 0;
    repeat (300) begin
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
      u = (idx == 0) || ($urandom_range(0, 39) == 0);
      l = ((idx % W) == W - 1) ^ ($urandom_range(0, 29) == 0);
      send($urandom, u, l);
      idx = (idx + 1) % FS;
    end
    dn_mode = 0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/motion_frame_sequencer.md
MOTION_FRAME_SEQUENCER -- requirements
Module: motion_frame_sequencer

Interface
REQ-001 Parameter FRAME_W, 1280, active pixels per line; legal range 2..4095.
REQ-002 Parameter FRAME_H, 720, lines per frame; legal range 1..4095.
REQ-003 Parameter WARMUP_FRAMES, 2, number of good frames completed before motion_valid rises.
REQ-004 Parameter BG_PERIOD, 4, background write-back performed on every BG_PERIOD-th good frame.
REQ-005 clk  in  1  single clock, all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 s_tvalid/s_tready  in/out  1/1  AXI-Stream pixel handshake.
REQ-008 s_tdata  in  32  pixel {R,G,B,X}.
REQ-009 s_tlast  in  1  end of line; s_tuser  in  1  start of frame.
REQ-010 dn_ready  in  1  downstream may accept a beat this cycle.
REQ-011 fm_pixel  out  32  pixel to frame manager; fm_enable  out  1  pixel strobe.
REQ-012 fm_last_in_frame  out  1  final pixel of frame; fm_wr_background  out  1  background write-back enable.
REQ-013 motion_valid  out  1  sticky, motion map is trustworthy; frame_count  out  16  good frames completed, wraps.
REQ-014 err_early_eol, err_late_eol, err_sof  out  1 each  single-cycle error pulses.

Function
REQ-015 Accept = s_tvalid & s_tready; s_tready = dn_ready in IDLE and ACTIVE, 0 in FLUSH.
REQ-016 FSM states IDLE, ACTIVE, FLUSH; reset state IDLE.
REQ-017 IDLE: accepted beats without s_tuser are dropped; an accepted beat with s_tuser is forwarded as pixel (0,0) and the FSM enters ACTIVE.
REQ-018 ACTIVE: each accepted beat is forwarded; x increments, wraps to 0 at FRAME_W-1 with y incrementing; y wraps to 0 at FRAME_H-1.
REQ-019 fm_pixel/fm_enable/fm_last_in_frame/fm_wr_background are registered, 1 cycle after accept; fm_enable is 0 in every cycle without a forwarded or padding beat.
REQ-020 fm_last_in_frame = 1 exactly on the beat at x=FRAME_W-1, y=FRAME_H-1; FSM then returns to IDLE.
REQ-021 Early EOL: s_tlast with x<FRAME_W-1 -> beat forwarded, err_early_eol pulses, FSM enters FLUSH.
REQ-022 Late EOL: x=FRAME_W-1 without s_tlast -> beat forwarded, err_late_eol pulses, FLUSH.
REQ-023 s_tuser with (x,y)!=(0,0) in ACTIVE -> beat dropped, err_sof pulses, FLUSH; early-EOL/late-EOL checks are suppressed on that beat.
REQ-024 FLUSH: one padding beat (fm_pixel=0, fm_enable=1) issued per cycle with dn_ready=1, continuing the x/y count until the padding beat at the last position carries fm_last_in_frame; FSM then enters IDLE.
REQ-025 Flushed frames do not increment frame_count or the BG_PERIOD phase counter; fm_wr_background=0 on every beat of a flushed frame.
REQ-026 fm_wr_background = 1 on every forwarded beat while frame_count<WARMUP_FRAMES, or while the BG phase counter is 0.
REQ-027 Good frame completion (fm_last_in_frame in ACTIVE) increments frame_count mod 2^16 and the BG phase counter mod BG_PERIOD.
REQ-028 motion_valid sets in the cycle frame_count reaches WARMUP_FRAMES; it clears only on reset.
REQ-029 dn_ready=0 freezes counters, FSM and all fm_* outputs except fm_enable, which is 0.

Reset
REQ-030 rst=0 at a rising edge: FSM IDLE, x=y=0, frame_count=0, BG phase=0, motion_valid=0, all fm_* and error outputs 0, s_tready=0 during reset.
REQ-031 Reset mid-frame abandons the frame without padding; the frame manager shares this reset.

Configuration
REQ-032 Macro MFS_ERR_STATS_EN compiled in: output err_total 8-bit counts all error pulses, saturating at 255, reset to 0.
REQ-033 Without MFS_ERR_STATS_EN: port err_total and its counter are absent; all other behaviour is identical.

Structure
REQ-034 Package motion_pkg holds FRAME_W/FRAME_H defaults, the FSM state enum, and the pixel word typedef.
REQ-035 Sub-module mfs_raster_counter (x/y counter with wrap and end-of-line/end-of-frame flags) is instantiated once.

Verification (FRAME_W=4, FRAME_H=2, WARMUP_FRAMES=2, BG_PERIOD=4)
REQ-036 Three clean frames (8 beats each, SOF on first beat, tlast on x=3) -> 24 fm_enable pulses, fm_last_in_frame on beats 8/16/24, frame_count=3, motion_valid rises after frame 2.
REQ-037 Beats before the first SOF -> dropped, no fm_enable, IDLE held.
REQ-038 tlast on x=1, y=0 -> err_early_eol pulses once, 6 padding beats with zero pixel, last one flags fm_last_in_frame, frame_count unchanged.
REQ-039 SOF at x=2, y=1 -> err_sof pulse, beat dropped, 2 padding beats, next SOF frame accepted normally.
REQ-040 dn_ready toggled 0/1 each cycle during a frame -> s_tready follows dn_ready, output sequence identical to the unstalled case; fm_wr_background seen on frames 1, 2, 5.
REQ-041 rst=0 at beat 5 of a frame -> all outputs 0 next cycle; the following SOF frame completes cleanly with frame_count=1.
